// File: rtl/add_sub_if.sv
// Start/done handshake and operand/result bundle for the sequential adder/subtractor.
interface add_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, mode, a, b, cin,
    input  ready, busy, done, sum, cout, ovf, zero
  );

  modport slave (
    input  start, mode, a, b, cin,
    output ready, busy, done, sum, cout, ovf, zero
  );
endinterface

// File: rtl/add_sub_seq.sv
// Multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per cycle, with carry/ovf/zero flags.
// Optional signed saturation of the result is enabled by defining ADD_SUB_SAT_EN.
module add_sub_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic      clk,
  input  logic      rst,
  add_sub_if.slave  bus
);
  localparam int N   = WIDTH / CHUNK;
  localparam int KW  = (N > 1) ? $clog2(N) : 1;
  localparam int MSB = WIDTH - 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic             a_msb;
  logic             b_msb;

  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] raw_sum;
  logic [WIDTH-1:0] final_sum;
  logic             raw_ovf;

  // Operands shift right one chunk per cycle, so the active chunk is always the low bits
  // and the result fills acc from the top; no variable part-selects are needed.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
    raw_sum   = WIDTH'({chunk_sum[CHUNK-1:0], acc} >> CHUNK);
    raw_ovf   = (a_msb == b_msb) && (raw_sum[MSB] != a_msb);
`ifdef ADD_SUB_SAT_EN
    if (raw_ovf) final_sum = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else         final_sum = raw_sum;
`else
    final_sum = raw_sum;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: only control state and visible outputs are reset; the operand pipeline is
      // always reloaded at accept, so resetting it would buy nothing.
      state  <= IDLE;
      k      <= '0;
      done_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples
      // pre-edge values regardless of statement order.
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q   <= bus.a;
            b_q   <= bus.mode ? ~bus.b : bus.b;
            carry <= bus.cin ^ bus.mode;
            a_msb <= bus.a[MSB];
            b_msb <= bus.b[MSB] ^ bus.mode;
            acc   <= '0;
            k     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_q >> CHUNK;
          b_q   <= b_q >> CHUNK;
          acc   <= raw_sum;
          carry <= chunk_sum[CHUNK];
          if (k == KW'(N - 1)) begin
            state  <= IDLE;
            k      <= '0;
            done_q <= 1'b1;
            sum_q  <= final_sum;
            cout_q <= chunk_sum[CHUNK];
            ovf_q  <= raw_ovf;
            zero_q <= (final_sum == '0);
          end else begin
            k <= k + KW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready = (state == IDLE);
  assign bus.busy  = (state == RUN);
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.ovf   = ovf_q;
  assign bus.zero  = zero_q;
endmodule

// File: tb/tb_add_sub_seq.sv
// Scoreboard bench for add_sub_seq (WIDTH=8, CHUNK=2): stimulus pushes expected results,
// a negedge monitor pops and compares on every done.
module tb_add_sub_seq;
  localparam int WIDTH = 8;
  localparam int CHUNK = 2;
  localparam int N     = WIDTH / CHUNK;

`ifdef ADD_SUB_SAT_EN
  localparam logic [7:0] POS_OVF_SUM = 8'h7F;
  localparam logic [7:0] NEG_OVF_SUM = 8'h80;
`else
  localparam logic [7:0] POS_OVF_SUM = 8'h80;
  localparam logic [7:0] NEG_OVF_SUM = 8'h7F;
`endif

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       zero;
  } exp_t;

  logic clk;
  logic rst;
  int   passed;
  int   total;
  exp_t sb[$];

  add_sub_if #(.WIDTH(WIDTH)) bus ();

  add_sub_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sum",  32'(bus.sum),  32'(e.sum));
        check("cout", 32'(bus.cout), 32'(e.cout));
        check("ovf",  32'(bus.ovf),  32'(e.ovf));
        check("zero", 32'(bus.zero), 32'(e.zero));
      end
    end
  end

  // Called at a negedge with ready=1; returns #1 after the accepting edge.
  task automatic issue(input logic mode, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic push, input logic [7:0] esum,
                       input logic ecout, input logic eovf, input logic ezero);
    exp_t e;
    check("ready_before_start", 32'(bus.ready), 32'd1);
    bus.start = 1'b1;
    bus.mode  = mode;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    if (push) begin
      e.sum  = esum;
      e.cout = ecout;
      e.ovf  = eovf;
      e.zero = ezero;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = 8'hA5;
    bus.b     = 8'h5A;
    bus.mode  = ~mode;
    bus.cin   = ~cin;
    check("busy_after_accept", 32'(bus.busy), 32'd1);
  endtask

  // Waits (bounded) for done; lat >= 0 also checks edges from accept to done.
  task automatic wait_done(input int lat);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
      else check("busy_while_running", 32'(bus.busy), 32'd1);
    end
    check("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      check("ready_in_done_cycle", 32'(bus.ready), 32'd1);
      if (lat >= 0) check("latency", 32'(n), 32'(lat));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    passed    = 0;
    total     = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_busy",  32'(bus.busy),  32'd0);
    check("rst_done",  32'(bus.done),  32'd0);
    check("rst_sum",   32'(bus.sum),   32'd0);
    check("rst_cout",  32'(bus.cout),  32'd0);
    check("rst_ovf",   32'(bus.ovf),   32'd0);
    check("rst_zero",  32'(bus.zero),  32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Plain add, with latency check.
    issue(1'b0, 8'h01, 8'h08, 1'b0, 1'b1, 8'h09, 1'b0, 1'b0, 1'b0);
    wait_done(N);
    @(negedge clk);

    // Subtract with and without borrow-in.
    issue(1'b1, 8'h03, 8'h0C, 1'b0, 1'b1, 8'hF7, 1'b0, 1'b0, 1'b0);
    wait_done(N);
    @(negedge clk);
    issue(1'b1, 8'h03, 8'h0C, 1'b1, 1'b1, 8'hF6, 1'b0, 1'b0, 1'b0);
    wait_done(N);
    @(negedge clk);

    // Positive and negative signed overflow.
    issue(1'b0, 8'h7F, 8'h01, 1'b0, 1'b1, POS_OVF_SUM, 1'b0, 1'b1, 1'b0);
    wait_done(N);
    @(negedge clk);
    issue(1'b1, 8'h80, 8'h01, 1'b0, 1'b1, NEG_OVF_SUM, 1'b1, 1'b1, 1'b0);
    wait_done(N);
    @(negedge clk);

    // Carry-out to zero, then back-to-back start in the done cycle.
    issue(1'b0, 8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    wait_done(N);
    issue(1'b0, 8'h12, 8'h34, 1'b1, 1'b1, 8'h47, 1'b0, 1'b0, 1'b0);
    wait_done(N);
    @(negedge clk);

    // Reset during the 2nd RUN cycle aborts without done.
    issue(1'b0, 8'h55, 8'h22, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_ready", 32'(bus.ready), 32'd1);
    check("abort_busy",  32'(bus.busy),  32'd0);
    check("abort_done",  32'(bus.done),  32'd0);
    check("abort_sum",   32'(bus.sum),   32'd0);
    check("abort_cout",  32'(bus.cout),  32'd0);
    check("abort_ovf",   32'(bus.ovf),   32'd0);
    check("abort_zero",  32'(bus.zero),  32'd0);
    dones = 0;
    repeat (N + 3) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);

    // Start while busy with different operands is ignored.
    issue(1'b1, 8'h40, 8'h10, 1'b0, 1'b1, 8'h30, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = 1'b0;
    bus.a     = 8'hFF;
    bus.b     = 8'hFF;
    bus.cin   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(-1);
    repeat (N + 2) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    check("idle_at_end", 32'(bus.ready), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/add_sub_seq.md
# add_sub_seq

Parametrised, multi-cycle binary adder/subtractor. It processes a WIDTH-bit operation CHUNK bits per clock, with a start/done handshake and carry, signed-overflow and zero flags. It is the sequential, width-generic successor of the team's 4-bit combinational adder/subtractor. It sits in datapaths where a full-width ripple path would not close timing and a fixed multi-cycle latency is acceptable.

## Interface
- WIDTH, 8: operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 2: bits processed per RUN cycle; 1 ≤ CHUNK ≤ WIDTH. N = WIDTH/CHUNK.
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when ready=1.
- mode  input  1  0 = add, 1 = subtract; latched at accept.
- a  input  WIDTH  minuend/addend; latched at accept.
- b  input  WIDTH  subtrahend/addend; latched at accept.
- cin  input  1  carry-in (add) or borrow-in (subtract); latched at accept.
- ready  output  1  high in IDLE; the block can accept start.
- busy  output  1  high in RUN; equals ~ready.
- done  output  1  one-cycle pulse; the result outputs were updated at this edge.
- sum  output  WIDTH  result; held until the next done.
- cout  output  1  carry out. For subtract, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.
- zero  output  1  sum == 0.

## Operation
- Add: sum/cout = a + b + cin.
- Subtract: sum/cout = a + ~b + ~cin, i.e. a − b − cin.
- States:
  - IDLE: ready=1.
  - RUN: busy=1, chunk counter k = 0..N−1.
- Transitions:
  - IDLE → RUN: on start=1. The edge latches a, b_eff (b, or ~b when mode=1), carry (cin, or ~cin when mode=1), and sets k=0.
  - RUN: each edge adds chunk k of a and b_eff plus the running carry, and stores CHUNK result bits and the new carry.
  - RUN → IDLE: on the edge where k=N−1. That same edge writes sum, cout, ovf and zero, and sets done=1 for one cycle.
- Overflow: ovf = (a[MSB] == b_eff[MSB]) && (raw_sum[MSB] != a[MSB]), computed on raw_sum before any saturation.
- zero is evaluated on the final (post-saturation) sum.
- start while busy=1 is ignored: no queuing, latched operands unaffected.
- Back-to-back: in the done cycle the state is IDLE and ready=1, so a start there is accepted.
- Input changes after accept have no effect on the running operation.

## Timing
- Reset values, effective the edge after rst=1:
  - state IDLE, ready=1, busy=0, done=0.
  - sum=0, cout=0, ovf=0, zero=0, k=0.
- Reset mid-RUN aborts the operation. No done is produced, and ready=1 on the next cycle.
- rst takes priority over start on the same edge.
- Latency: start accepted at edge E → done high and results valid in the cycle after edge E+N.
- Throughput: one operation per N+1 cycles when start is held high.
- The flag outputs change only at a done edge or at reset.
- N=1 (CHUNK=WIDTH) is legal: done is asserted one edge after accept.

## Configuration
- ADD_SUB_SAT_EN defined:
  - On ovf=1, sum clamps to the signed limit: 0111…1 for positive overflow (a[MSB]=0), 1000…0 for negative overflow.
  - ovf and cout still report the unsaturated operation.
- ADD_SUB_SAT_EN undefined: sum wraps modulo 2^WIDTH; no clamp logic is built.

## Test plan
All scenarios use WIDTH=8, CHUNK=2 (N=4).
- Add a=0x01, b=0x08, cin=0 → sum=0x09, cout=0, ovf=0, zero=0; done exactly 4 edges after accept; busy=1 for those 4 cycles.
- Subtract a=0x03, b=0x0C, cin=0 → sum=0xF7, cout=0 (borrow), ovf=0. Repeat with cin=1 → sum=0xF6.
- Add a=0x7F, b=0x01 → ovf=1, cout=0; sum=0x80 (wrap), or sum=0x7F with ADD_SUB_SAT_EN.
- Subtract a=0x80, b=0x01, cin=0 → ovf=1, cout=1; sum=0x7F (wrap), or sum=0x80 with ADD_SUB_SAT_EN.
- Add a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, zero=1, ovf=0. Issue start in the done cycle → second op accepted with no idle gap.
- Assert rst at the 2nd RUN cycle → no done, all outputs 0, ready=1 next cycle. Separately, pulse start while busy=1 with different operands → result matches the original operands.
